// File: rtl/rr_arbiter_eight.sv
// Round-robin arbiter driving the 3-bit select of mux_eight.
// Grants one requester at a time over a valid/ready handshake.
module rr_arbiter_eight #(
    parameter int N_REQ = 8,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] pick;
    logic             found;
    logic [SEL_W-1:0] idx;

    // Find the first set request, searching upward from ptr with wrap.
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr_q + SEL_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        ack       = '0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    // A transfer wins even if the requester withdrew this cycle.
                    ack     = N_REQ'(1) << sel_q;
                    ptr_d   = sel_q + SEL_W'(1);
                    state_d = IDLE;
                end else if (!req[sel_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, select and priority pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
        end
    end

    assign sel = sel_q;

endmodule

// File: tb/tb_rr_arbiter_eight.sv
// Directed bench for rr_arbiter_eight.
// Expected values are hand-computed per step.
module tb_rr_arbiter_eight;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       out_ready;
    logic [2:0] sel;
    logic       out_valid;
    logic [7:0] ack;
    logic       busy;

    int checks;
    int failures;

    rr_arbiter_eight dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .sel       (sel),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] mux_in [8];
        checks    = 0;
        failures  = 0;
        mux_in    = '{8'h11, 8'h22, 8'h55, 8'h44,
                      8'h66, 8'h77, 8'h88, 8'h99};
        rst_n     = 1'b0;
        req       = 8'hFF;
        out_ready = 1'b0;

        // Reset with all requests high.
        tick();
        tick();
        check("rst_sel",   32'(sel),       32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ack",   32'(ack),       32'd0);
        check("rst_busy",  32'(busy),      32'd0);

        // Fairness: all request, grants rotate 0..7,0.
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            check("rr_sel",   32'(sel),       32'(k % 8));
            check("rr_ack",   32'(ack),       32'(8'h01 << (k % 8)));
            check("rr_valid", 32'(out_valid), 32'd1);
            tick();
            check("rr_bubble_valid", 32'(out_valid), 32'd0);
            check("rr_bubble_ack",   32'(ack),       32'd0);
        end

        // Single source c; ptr is 1 here.
        req = 8'h04;
        tick();
        check("single_sel",  32'(sel),         32'd2);
        check("single_ack",  32'(ack),         32'h04);
        check("single_busy", 32'(busy),        32'd1);
        check("single_data", 32'(mux_in[sel]), 32'h55);
        req = 8'h00;
        tick();
        check("single_idle_valid", 32'(out_valid), 32'd0);
        check("single_idle_busy",  32'(busy),      32'd0);
        check("single_hold_sel",   32'(sel),       32'd2);
        tick();
        check("idle_noreq_valid", 32'(out_valid), 32'd0);

        // Wrap: grant 6 then req a and h -> 7 then 0.
        req = 8'h40;
        tick();
        check("wrap_g6", 32'(sel), 32'd6);
        req = 8'h81;
        check("wrap_g6_ack", 32'(ack), 32'h40);
        tick();
        tick();
        check("wrap_sel7", 32'(sel), 32'd7);
        check("wrap_ack7", 32'(ack), 32'h80);
        tick();
        tick();
        check("wrap_sel0", 32'(sel), 32'd0);
        check("wrap_ack0", 32'(ack), 32'h01);
        req = 8'h00;
        tick();

        // Backpressure for 5 cycles; ptr is 1.
        req       = 8'h08;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_sel",   32'(sel),       32'd3);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ack",   32'(ack),       32'd0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ack", 32'(ack), 32'h08);
        tick();
        check("bp_done_valid", 32'(out_valid), 32'd0);
        check("bp_done_ack",   32'(ack),       32'd0);
        req = 8'h00;

        // Abort: requester f withdraws; ptr stays 4.
        out_ready = 1'b0;
        req       = 8'h20;
        tick();
        check("abort_sel",   32'(sel),       32'd5);
        check("abort_valid", 32'(out_valid), 32'd1);
        req = 8'h00;
        tick();
        check("abort_valid_drop", 32'(out_valid), 32'd0);
        check("abort_ack",        32'(ack),       32'd0);
        req = 8'h21;
        tick();
        check("abort_ptr_kept", 32'(sel), 32'd5);

        // Async reset mid-GRANT, between edges.
        #2;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_sel",   32'(sel),       32'd0);
        check("arst_ack",   32'(ack),       32'd0);
        req   = 8'h00;
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
